// File: rtl/baby_store_responder_if.sv
// CPU RAM port plus host loader port of the Baby store responder.
interface baby_store_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  // CPU side
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [DATA_W-1:0] cpu_data_i;
  logic              cpu_rw_en_i;
  logic [DATA_W-1:0] cpu_data_o;
  logic              cpu_halted_i;
  logic              cpu_hold_o;
  // host loader side
  logic              host_mode_i;
  logic              host_owned_o;
  logic              host_valid_i;
  logic              host_ready_o;
  logic              host_we_i;
  logic [ADDR_W-1:0] host_addr_i;
  logic [DATA_W-1:0] host_wdata_i;
  logic              host_rvalid_o;
  logic              host_rready_i;
  logic [DATA_W-1:0] host_rdata_o;

  modport slave (
    input  cpu_addr_i, cpu_data_i, cpu_rw_en_i, cpu_halted_i,
    input  host_mode_i, host_valid_i, host_we_i, host_addr_i, host_wdata_i, host_rready_i,
    output cpu_data_o, cpu_hold_o, host_owned_o, host_ready_o, host_rvalid_o, host_rdata_o
  );

  modport master (
    output cpu_addr_i, cpu_data_i, cpu_rw_en_i, cpu_halted_i,
    output host_mode_i, host_valid_i, host_we_i, host_addr_i, host_wdata_i, host_rready_i,
    input  cpu_data_o, cpu_hold_o, host_owned_o, host_ready_o, host_rvalid_o, host_rdata_o
  );
endinterface

// File: rtl/baby_store_responder.sv
// Baby store responder: 2**ADDR_W-word store serving the CPU RAM port, with
// exclusive host-loader ownership arbitrated by a small FSM.
module baby_store_responder #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 5,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic         clock,
  input  logic         reset_i,
  baby_store_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {S_INIT, S_RUN, S_HOLD, S_HOST, S_RELEASE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clear_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              host_ready, host_wr, host_rd, cpu_wr;

  // handshake qualification and state-decoded outputs
  always_comb begin
    host_ready = (state == S_HOST) && bus.host_mode_i && (!rvalid || bus.host_rready_i);
    host_wr    = bus.host_valid_i && host_ready && bus.host_we_i;
    host_rd    = bus.host_valid_i && host_ready && !bus.host_we_i;
    cpu_wr     = (state == S_RUN) && bus.cpu_rw_en_i;
  end

  assign bus.cpu_hold_o    = (state != S_RUN);
  assign bus.host_owned_o  = (state == S_HOST);
  assign bus.host_ready_o  = host_ready;
  assign bus.host_rvalid_o = rvalid;
  assign bus.host_rdata_o  = rdata;
  // CPU sees zeros whenever it is held, so a held CPU never latches stale data
  assign bus.cpu_data_o    = (state == S_RUN) ? mem[bus.cpu_addr_i] : '0;

  // ownership FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:    if (clear_cnt == '1) state_nxt = S_RUN;
      S_RUN:     if (bus.host_mode_i) state_nxt = S_HOLD;
      S_HOLD:    state_nxt = S_HOST;
      // a pending read response must drain before the host lets go
      S_HOST:    if (!bus.host_mode_i && !rvalid) state_nxt = S_RELEASE;
      S_RELEASE: state_nxt = S_RUN;
      default:   state_nxt = S_INIT;
    endcase
  end

  // state register and clear counter
  always_ff @(posedge clock) begin
    if (reset_i) begin
      if (CLEAR_ON_RESET) state <= S_INIT;
      else                state <= S_RUN;
      clear_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_INIT) clear_cnt <= clear_cnt + 1'b1;
    end
  end

  // store writes; the three sources are exclusive by state
  always_ff @(posedge clock) begin
    if (!reset_i) begin
      if (state == S_INIT) mem[clear_cnt]       <= '0;
      else if (cpu_wr)     mem[bus.cpu_addr_i]  <= bus.cpu_data_i;
      else if (host_wr)    mem[bus.host_addr_i] <= bus.host_wdata_i;
    end
  end

  // host read response register, one outstanding read at most
  always_ff @(posedge clock) begin
    if (reset_i) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else if (host_rd) begin
      rvalid <= 1'b1;
      rdata  <= mem[bus.host_addr_i];
    end else if (rvalid && bus.host_rready_i) begin
      rvalid <= 1'b0;
    end
  end
endmodule
